// File: rtl/store_buffer.sv
// Store buffer: a circular FIFO of pending CPU stores that drains to data
// memory one word per cycle. Loads are forwarded from the newest matching
// entry. A load miss owns the memory port for its cycle and stalls the drain.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_addr,
  output logic                       ld_hit,
  output logic [31:0]                ld_data,
  output logic [31:0]                dm_addr,
  output logic [31:0]                dm_wdata,
  output logic                       dm_write,
  output logic                       dm_read,
  input  logic [31:0]                dm_rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_match;
  logic [31:0]      w_fwd;
  logic [PTR_W-1:0] w_idx;
  logic             w_hit, w_miss, w_drain, w_push;

  // Byte-offset bits of the addresses carry no meaning for word accesses.
  logic w_unused;
  assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};

  // Walk entries oldest to newest so the newest match wins; validity is
  // derived from distance to head, so stale data past count is never seen.
  always_comb begin
    w_match = 1'b0;
    w_fwd   = '0;
    w_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_mem[w_idx].addr == ld_addr[31:2])) begin
        w_match = 1'b1;
        w_fwd   = r_mem[w_idx].data;
      end
    end
  end

  // Arbitration: load miss first, drain otherwise; rst silences the port.
  always_comb begin
    st_ready = (r_count < CNT_W'(DEPTH));
    w_hit    = ld_valid & w_match;
    w_miss   = ld_valid & ~w_match & ~rst;
    w_drain  = (r_count != '0) & ~w_miss & ~rst;
    w_push   = st_valid & st_ready & ~rst;
    empty    = (r_count == '0);
    count    = r_count;
    ld_hit   = w_hit;
    ld_data  = w_hit ? w_fwd : dm_rdata;
    dm_read  = w_miss;
    dm_write = w_drain;
    dm_addr  = '0;
    dm_wdata = '0;
    if (w_miss) begin
      dm_addr = {ld_addr[31:2], 2'b00};
    end else if (w_drain) begin
      dm_addr  = {r_mem[r_head].addr, 2'b00};
      dm_wdata = r_mem[r_head].data;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards every pending store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset: lookup and drain are gated by occupancy.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= '{addr: st_addr[31:2], data: st_data};
  end

endmodule
